// File: rtl/vga_pixel_source_if.sv
// Frame-buffer read port between the VGA pixel source and its pixel memory.
// The memory returns the word for rd_addr in the cycle after the address is presented.
interface vga_pixel_source_if;
  logic [16:0] rd_addr;
  logic        rd_en;
  logic [15:0] rd_data;

  modport master (
    output rd_addr,
    output rd_en,
    input  rd_data
  );

  modport slave (
    input  rd_addr,
    input  rd_en,
    output rd_data
  );
endinterface

// File: rtl/vga_pixel_source.sv
// VGA timing generator that fetches a half-resolution RGB565 frame buffer
// and emits a pixel-doubled RGB444 stream. A 2-bit phase counter divides the
// system clock by four. The counters advance on tick edge T and the read
// address is issued on that same edge. Memory data is captured on edge T+1.
// All display outputs change together on edge T+2.
module vga_pixel_source #(
  parameter int H_ACT = 640,
  parameter int V_ACT = 480,
  parameter int H_FP  = 16,
  parameter int H_SW  = 96,
  parameter int H_BP  = 48,
  parameter int V_FP  = 10,
  parameter int V_SW  = 2,
  parameter int V_BP  = 33
) (
  input  logic                       sys_clk,
  input  logic                       reset,
  vga_pixel_source_if.master         fb,
  output logic                       pixel_tick,
  output logic                       hsync,
  output logic                       vsync,
  output logic                       DE,
  output logic [9:0]                 x_pixel,
  output logic [9:0]                 y_pixel,
  output logic [3:0]                 cam_r,
  output logic [3:0]                 cam_g,
  output logic [3:0]                 cam_b,
  output logic                       frame_start
);

  localparam logic [11:0] H_ACT_C  = 12'(H_ACT);
  localparam logic [11:0] H_SYNC_S = 12'(H_ACT + H_FP);
  localparam logic [11:0] H_SYNC_E = 12'(H_ACT + H_FP + H_SW);
  localparam logic [11:0] H_LAST   = 12'(H_ACT + H_FP + H_SW + H_BP - 1);
  localparam logic [11:0] V_ACT_C  = 12'(V_ACT);
  localparam logic [11:0] V_SYNC_S = 12'(V_ACT + V_FP);
  localparam logic [11:0] V_SYNC_E = 12'(V_ACT + V_FP + V_SW);
  localparam logic [11:0] V_LAST   = 12'(V_ACT + V_FP + V_SW + V_BP - 1);
  // Each source pixel covers a 2x2 block, so the buffer is half the width.
  localparam logic [16:0] SRC_W    = 17'(H_ACT / 2);

  logic [1:0]  phase_q;
  logic [11:0] h_q, h_d;
  logic [11:0] v_q, v_d;
  logic [16:0] rd_addr_q, addr_d;
  logic        rd_en_q;
  logic        vis_d, vis_q;
  logic        hsync_n, vsync_n;
  logic        tick1_q, tick2_q;
  logic [11:0] data_q;
  logic        de_q;
  logic [9:0]  x_q, y_q;
  logic        hsync_q, vsync_q;
  logic [11:0] cam_q;
  logic        frame_start_q;
  logic        unused_rd_bits;

  // The RGB565 bits that are dropped when reducing to RGB444.
  assign unused_rd_bits = ^{fb.rd_data[11], fb.rd_data[6:5], fb.rd_data[0]};

  assign pixel_tick = (phase_q == 2'd3);

  // Next horizontal and vertical position. The vertical counter moves only when the line wraps.
  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (pixel_tick) begin
      if (h_q == H_LAST) begin
        h_d = 12'd0;
        if (v_q == V_LAST) begin
          v_d = 12'd0;
        end else begin
          v_d = v_q + 12'd1;
        end
      end else begin
        h_d = h_q + 12'd1;
      end
    end
  end

  // Visibility and address of the upcoming position, plus sync levels of the held position.
  always_comb begin
    vis_d   = (h_d < H_ACT_C) && (v_d < V_ACT_C);
    addr_d  = 17'(v_d[11:1]) * SRC_W + 17'(h_d[11:1]);
    vis_q   = (h_q < H_ACT_C) && (v_q < V_ACT_C);
    hsync_n = !((h_q >= H_SYNC_S) && (h_q < H_SYNC_E));
    vsync_n = !((v_q >= V_SYNC_S) && (v_q < V_SYNC_E));
  end

  // Counters, read request, data capture and the output stage are advanced together.
  // The tick delay line keeps the three stages aligned.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      phase_q       <= 2'd0;
      h_q           <= H_LAST;
      v_q           <= V_LAST;
      rd_addr_q     <= 17'd0;
      rd_en_q       <= 1'b0;
      tick1_q       <= 1'b0;
      tick2_q       <= 1'b0;
      data_q        <= 12'd0;
      de_q          <= 1'b0;
      x_q           <= 10'd0;
      y_q           <= 10'd0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      cam_q         <= 12'd0;
      frame_start_q <= 1'b0;
    end else begin
      phase_q       <= phase_q + 2'd1;
      h_q           <= h_d;
      v_q           <= v_d;
      tick1_q       <= pixel_tick;
      tick2_q       <= tick1_q;
      frame_start_q <= 1'b0;
      if (pixel_tick) begin
        rd_en_q <= vis_d;
        if (vis_d) begin
          rd_addr_q <= addr_d;
        end
      end
      if (tick1_q) begin
        data_q <= {fb.rd_data[15:12], fb.rd_data[10:7], fb.rd_data[4:1]};
      end
      if (tick2_q) begin
        de_q          <= vis_q;
        x_q           <= h_q[9:0];
        y_q           <= v_q[9:0];
        hsync_q       <= hsync_n;
        vsync_q       <= vsync_n;
        cam_q         <= vis_q ? data_q : 12'd0;
        frame_start_q <= vis_q && (h_q == 12'd0) && (v_q == 12'd0);
      end
    end
  end

  assign fb.rd_addr  = rd_addr_q;
  assign fb.rd_en    = rd_en_q;
  assign DE          = de_q;
  assign x_pixel     = x_q;
  assign y_pixel     = y_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign cam_r       = cam_q[11:8];
  assign cam_g       = cam_q[7:4];
  assign cam_b       = cam_q[3:0];
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_pixel_source.sv
// Bench for vga_pixel_source using a reduced raster so that full frames stay short.
// A cycle-counting model queues the expected output for each pixel when the
// counters advance. The queued value is retired when it falls due.
module tb_vga_pixel_source;

  localparam int H_ACT = 16;
  localparam int H_FP  = 2;
  localparam int H_SW  = 3;
  localparam int H_BP  = 3;
  localparam int V_ACT = 8;
  localparam int V_FP  = 1;
  localparam int V_SW  = 2;
  localparam int V_BP  = 2;
  localparam int H_TOT = H_ACT + H_FP + H_SW + H_BP;
  localparam int V_TOT = V_ACT + V_FP + V_SW + V_BP;
  localparam int FRAME_CYC = H_TOT * V_TOT * 4;
  localparam int SRC_W = H_ACT / 2;
  localparam int MAX_ADDR = (V_ACT / 2 - 1) * SRC_W + SRC_W - 1;

  typedef struct {
    int         due;
    logic       de;
    logic [9:0] x;
    logic [9:0] y;
    logic       hs;
    logic       vs;
    logic [11:0] cam;
    logic       fs;
  } pixRec_t;

  logic        sysClk = 1'b0;
  logic        reset;
  logic        pixelTick, hsync, vsync, de, frameStart;
  logic [9:0]  xPixel, yPixel;
  logic [3:0]  camR, camG, camB;
  logic [15:0] mem [0:127];

  vga_pixel_source_if fb();

  assign fb.rd_data = mem[fb.rd_addr[6:0]];

  vga_pixel_source #(
    .H_ACT(H_ACT), .V_ACT(V_ACT),
    .H_FP(H_FP), .H_SW(H_SW), .H_BP(H_BP),
    .V_FP(V_FP), .V_SW(V_SW), .V_BP(V_BP)
  ) dut (
    .sys_clk     (sysClk),
    .reset       (reset),
    .fb          (fb),
    .pixel_tick  (pixelTick),
    .hsync       (hsync),
    .vsync       (vsync),
    .DE          (de),
    .x_pixel     (xPixel),
    .y_pixel     (yPixel),
    .cam_r       (camR),
    .cam_g       (camG),
    .cam_b       (camB),
    .frame_start (frameStart)
  );

  // 100 MHz system clock
  always #5 sysClk = ~sysClk;

  int testCount = 0;
  int failCount = 0;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    testCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic logic [11:0] toRgb444(input logic [15:0] w);
    return {w[15:12], w[10:7], w[4:1]};
  endfunction

  // Model state: edges since reset release, raster position, and the expected output record.
  int      edgeN = 0;
  int      mh = H_TOT - 1;
  int      mv = V_TOT - 1;
  logic [16:0] expAddr = 17'd0;
  logic    expEn = 1'b0;
  pixRec_t pending[$];
  pixRec_t cur;
  int      curDue = -1;
  logic    checkEn = 1'b0;

  // Advance the model on every clock edge. Each counter advance queues the pixel that must appear two edges later.
  always @(posedge sysClk) begin
    pixRec_t rec;
    logic vis;
    if (reset) begin
      edgeN = 0;
      mh = H_TOT - 1;
      mv = V_TOT - 1;
      expAddr = 17'd0;
      expEn = 1'b0;
      pending.delete();
      cur = '{due: -1, de: 1'b0, x: 10'd0, y: 10'd0, hs: 1'b1, vs: 1'b1, cam: 12'd0, fs: 1'b0};
      curDue = -1;
    end else begin
      edgeN++;
      if (edgeN % 4 == 0) begin
        mh++;
        if (mh == H_TOT) begin
          mh = 0;
          mv++;
          if (mv == V_TOT) mv = 0;
        end
        vis = (mh < H_ACT) && (mv < V_ACT);
        expEn = vis;
        if (vis) expAddr = 17'((mv / 2) * SRC_W + mh / 2);
        rec.due = edgeN + 2;
        rec.de  = vis;
        rec.x   = 10'(mh);
        rec.y   = 10'(mv);
        rec.hs  = !((mh >= H_ACT + H_FP) && (mh < H_ACT + H_FP + H_SW));
        rec.vs  = !((mv >= V_ACT + V_FP) && (mv < V_ACT + V_FP + V_SW));
        rec.cam = vis ? toRgb444(mem[(mv / 2) * SRC_W + mh / 2]) : 12'd0;
        rec.fs  = (mh == 0) && (mv == 0);
        pending.push_back(rec);
      end
      if (pending.size() > 0 && pending[0].due == edgeN) begin
        cur = pending.pop_front();
        curDue = edgeN;
      end
    end
  end

  // Frame statistics and post-reset bookkeeping
  int   fsSeen = 0;
  logic statsDone = 1'b0;
  int   cycCnt = 0, deCnt = 0, hsLowCnt = 0, vsLowCnt = 0;
  logic prevHs = 1'b1, prevVs = 1'b1;
  logic postRst = 1'b0;
  logic [16:0] maxAddr = 17'd0;

  // Compare every DUT output against the model away from the active edge.
  always @(negedge sysClk) begin
    if (checkEn) begin
      checkOutput("pixel_tick", 64'(pixelTick), 64'(edgeN % 4 == 3));
      checkOutput("rd_en", 64'(fb.rd_en), 64'(expEn));
      checkOutput("rd_addr", 64'(fb.rd_addr), 64'(expAddr));
      checkOutput("de", 64'(de), 64'(cur.de));
      checkOutput("x_pixel", 64'(xPixel), 64'(cur.x));
      checkOutput("y_pixel", 64'(yPixel), 64'(cur.y));
      checkOutput("hsync", 64'(hsync), 64'(cur.hs));
      checkOutput("vsync", 64'(vsync), 64'(cur.vs));
      checkOutput("cam", 64'({camR, camG, camB}), 64'(cur.cam));
      checkOutput("frame_start", 64'(frameStart), 64'(cur.fs && (curDue == edgeN)));
      if (cur.de && cur.x < 10'd2 && cur.y < 10'd2)
        checkOutput("cam_f81f", 64'({camR, camG, camB}), 64'h0F0F);

      if (fb.rd_addr > maxAddr) maxAddr = fb.rd_addr;
      if (prevHs && !hsync) checkOutput("hsync_start_x", 64'(xPixel), 64'(H_ACT + H_FP));
      if (prevVs && !vsync) checkOutput("vsync_start_y", 64'(yPixel), 64'(V_ACT + V_FP));
      prevHs = hsync;
      prevVs = vsync;

      if (postRst && de) begin
        checkOutput("post_rst_xy", 64'({xPixel, yPixel}), 64'd0);
        checkOutput("post_rst_fs", 64'(frameStart), 64'd1);
        postRst = 1'b0;
      end

      if (frameStart) begin
        if (fsSeen > 0 && !statsDone) begin
          checkOutput("frame_period", 64'(cycCnt), 64'(FRAME_CYC));
          checkOutput("de_cycles", 64'(deCnt), 64'(H_ACT * V_ACT * 4));
          checkOutput("hsync_low_cycles", 64'(hsLowCnt), 64'(H_SW * 4 * V_TOT));
          checkOutput("vsync_low_cycles", 64'(vsLowCnt), 64'(V_SW * H_TOT * 4));
          statsDone = 1'b1;
        end
        fsSeen++;
        cycCnt = 0; deCnt = 0; hsLowCnt = 0; vsLowCnt = 0;
      end
      if (fsSeen > 0 && !statsDone) begin
        cycCnt++;
        if (de) deCnt++;
        if (!hsync) hsLowCnt++;
        if (!vsync) vsLowCnt++;
      end
    end
  end

  // Drive reset to rstVal at a falling edge and hold it for the given number of cycles.
  task automatic applyStimulus(input logic rstVal, input int cycles);
    @(negedge sysClk);
    reset = rstVal;
    repeat (cycles) @(negedge sysClk);
  endtask

  initial begin
    logic found;
    for (int i = 0; i < 128; i++) mem[i] = 16'($urandom);
    mem[0] = 16'hF81F;
    reset = 1'b1;
    @(posedge sysClk);
    #1 checkEn = 1'b1;
    applyStimulus(1'b1, 2);
    applyStimulus(1'b0, 2 * FRAME_CYC + 40);

    // Reset in the middle of line 5, then expect a clean restart at pixel (0,0).
    found = 1'b0;
    for (int i = 0; i < FRAME_CYC && !found; i++) begin
      @(negedge sysClk);
      if (mv == 5 && mh == 10) found = 1'b1;
    end
    checkOutput("midframe_reach", 64'(found), 64'd1);
    applyStimulus(1'b1, 3);
    postRst = 1'b1;
    applyStimulus(1'b0, FRAME_CYC + 40);

    checkOutput("stats_done", 64'(statsDone), 64'd1);
    checkOutput("post_rst_seen", 64'(postRst), 64'd0);
    checkOutput("max_rd_addr", 64'(maxAddr), 64'(MAX_ADDR));

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/vga_pixel_source.md
VGA_PIXEL_SOURCE -- requirements
Module: vga_pixel_source

Interface
REQ-001 Parameter H_ACT, default 640: visible pixels per line.
REQ-002 Parameter V_ACT, default 480: visible lines per frame.
REQ-003 Parameter H_FP/H_SW/H_BP, defaults 16/96/48: horizontal front porch, sync width and back porch, in pixels.
REQ-004 Parameter V_FP/V_SW/V_BP, defaults 10/2/33: vertical front porch, sync width and back porch, in lines.
REQ-005 sys_clk  in  1: single clock for all logic (100 MHz).
REQ-006 reset  in  1: synchronous, active-high reset.
REQ-007 rd_addr  out  17: frame-buffer read address for a 320x240 RGB565 buffer.
REQ-008 rd_en  out  1: read strobe, high when rd_addr targets a visible pixel.
REQ-009 rd_data  in  16: RGB565 word, valid exactly 1 sys_clk after rd_addr/rd_en.
REQ-010 pixel_tick  out  1: one-cycle pulse marking a pixel-counter advance.
REQ-011 hsync, vsync  out  1 each: active-low sync pulses.
REQ-012 DE  out  1: display enable (visible region).
REQ-013 x_pixel, y_pixel  out  10 each: coordinates of the current output pixel.
REQ-014 cam_r, cam_g, cam_b  out  4 each: RGB444 pixel aligned with DE/x_pixel/y_pixel.
REQ-015 frame_start  out  1: one-cycle pulse when the outputs present pixel (0,0).

Function
REQ-016 A 2-bit phase counter SHALL run 0,1,2,3,0,...; pixel_tick SHALL be high in phase 3 only (25 MHz pixel rate).
REQ-017 Horizontal counter h (0..H_TOT-1, H_TOT=800) SHALL advance on each edge where pixel_tick=1 and wrap to 0 after H_TOT-1.
REQ-018 Vertical counter v (0..V_TOT-1, V_TOT=525) SHALL advance only when h wraps, and SHALL wrap to 0 after V_TOT-1.
REQ-019 Counter-stage visibility SHALL be vis = (h<H_ACT)&&(v<V_ACT).
REQ-020 Counter-stage syncs SHALL be low for H_ACT+H_FP <= h < H_ACT+H_FP+H_SW, and likewise for v.
REQ-021 rd_addr and rd_en SHALL be registered on the same edge as the counter update, computed from the new h/v: rd_addr=(v>>1)*320+(h>>1); rd_en=vis.
REQ-022 Outside the visible region, rd_addr SHALL hold its last visible value and rd_en SHALL be 0.
REQ-023 rd_data SHALL be sampled on the edge 1 cycle after the rd_addr update (edge T+1).
REQ-024 DE, x_pixel, y_pixel, hsync, vsync and cam_* SHALL all update together on edge T+2 and hold for 4 cycles; there SHALL be no skew between them.
REQ-025 cam_r=rd_data[15:12], cam_g=rd_data[10:7], cam_b=rd_data[4:1] when DE=1; cam_*=0 when DE=0.
REQ-026 x_pixel/y_pixel SHALL carry the raw h/v values (including blanking, truncated to 10 bits); consumers gate them with DE.
REQ-027 frame_start SHALL be high for exactly the single cycle following edge T+2 of pixel (0,0).
REQ-028 Each source pixel SHALL be displayed as a 2x2 block; rd_addr maximum SHALL be 76799.

Reset
REQ-029 On reset, phase SHALL be 0, h=H_TOT-1, and v=V_TOT-1, so the first tick advances the counters to (0,0).
REQ-030 Reset values SHALL be: rd_addr=0, rd_en=0, DE=0, x_pixel=0, y_pixel=0, hsync=1, vsync=1, cam_*=0, frame_start=0, pixel_tick=0.
REQ-031 Reset asserted mid-frame SHALL restore REQ-029/030 state on the next edge, with no partial pixel emitted.

Verification
REQ-032 Release reset and count cycles -> pixel_tick on cycles 4, 8, 12, ...; rd_addr=0 and rd_en=1 after the first tick; DE=1, x=0, y=0 and frame_start=1 two cycles later.
REQ-033 RAM model returns 0xF81F at address 0 -> cam_r=0xF, cam_g=0x0, cam_b=0xF at (0,0) and at (1,0), (0,1), (1,1).
REQ-034 Run one full frame -> exactly 640x480 DE pixels; hsync low for 96 ticks starting at h=656; vsync low for lines 490-491; 800x525x4 = 1,680,000 cycles between frame_start pulses.
REQ-035 Pixel (639,479) -> rd_addr=76799; next tick gives rd_en=0 and DE=0 two cycles later, with cam_*=0.
REQ-036 Assert reset at line 200, pixel 300 -> all outputs match REQ-030 on the next edge; after release, the first DE pixel is (0,0) with frame_start.
REQ-037 Scoreboard check over a full frame -> every DE=1 cycle satisfies cam_* == convert(mem[(y>>1)*320+(x>>1)]).
